// File: rtl/hc05_at_responder.sv
// hc05_at_responder: far-end HC-05 model. An 8N1 UART receiver feeds either an
// AT-command line collector (replies "OK\r\n" / "ERROR\r\n") or a transparent
// echo path, and an 8N1 UART transmitter sends the result back on txd.
module hc05_at_responder #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600,
    parameter int MAX_LINE = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    output logic       txd,
    input  logic       at_mode,
    output logic       busy,
    output logic       frame_err,
    output logic [7:0] cmd_count,
    output logic [7:0] err_count
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 2;
    localparam int LW  = $clog2(MAX_LINE + 1);

    // Countdown reloads: first sample lands DIV/2 after the synchronized edge,
    // later samples every DIV cycles.
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 2);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(DIV - 1);
    localparam logic [LW-1:0] LINE_MAX  = LW'(MAX_LINE);

    typedef enum logic {RX_IDLE, RX_BUSY} rx_state_t;
    typedef enum logic [1:0] {IDLE, COLLECT, RESPOND, ECHO} state_t;

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic            rxd_meta, rxd_sync, rxd_q;
    rx_state_t       rx_state;
    logic [CW-1:0]   rx_cnt;
    logic [3:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            rx_valid;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_q    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_q    <= rxd_sync;
        end
    end

    // Frame receiver: bit 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rxd_q && !rxd_sync) begin
                        rx_state <= RX_BUSY;
                        rx_cnt   <= HALF_LOAD;
                        rx_bit   <= '0;
                    end
                end
                RX_BUSY: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end else begin
                        rx_cnt <= BIT_LOAD;
                        rx_bit <= rx_bit + 4'd1;
                        if (rx_bit == 4'd0) begin
                            // High at mid-start means a glitch, not a frame.
                            if (rxd_sync) rx_state <= RX_IDLE;
                        end else if (rx_bit == 4'd9) begin
                            rx_state <= RX_IDLE;
                            if (rxd_sync) rx_valid  <= 1'b1;
                            else          frame_err <= 1'b1;
                        end else begin
                            rx_shift <= {rxd_sync, rx_shift[7:1]};
                        end
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    logic            tx_busy;
    logic [CW-1:0]   tx_cnt;
    logic [3:0]      tx_left;
    logic [8:0]      tx_shift;
    logic            tx_load;
    logic [7:0]      tx_byte;
    logic            tx_last;
    logic            tx_ready;

    // tx_last marks the final cycle of a stop bit; loading then keeps bytes
    // back-to-back with no idle time between them.
    assign tx_last  = tx_busy && (tx_cnt == '0) && (tx_left == 4'd0);
    assign tx_ready = !tx_busy || tx_last;

    // Shifter: start bit on load, then 8 data bits and the stop bit, DIV cycles each.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_left  <= '0;
            tx_shift <= '1;
        end else if (tx_load) begin
            txd      <= 1'b0;
            tx_busy  <= 1'b1;
            tx_shift <= {1'b1, tx_byte};
            tx_left  <= 4'd9;
            tx_cnt   <= BIT_LOAD;
        end else if (tx_busy) begin
            if (tx_cnt != '0) begin
                tx_cnt <= tx_cnt - 1'b1;
            end else if (tx_left != 4'd0) begin
                txd      <= tx_shift[0];
                tx_shift <= {1'b1, tx_shift[8:1]};
                tx_left  <= tx_left - 4'd1;
                tx_cnt   <= BIT_LOAD;
            end else begin
                tx_busy <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t          state, state_n;
    logic            mode_q, mode_n, mode_eff;
    logic [LW-1:0]   line_len, len_n;
    logic            ovf, ovf_n;
    logic [7:0]      pre0, pre0_n, pre1, pre1_n;
    logic            reply_err, reply_err_n;
    logic [2:0]      rom_idx, rom_idx_n;
    logic [2:0]      reply_len;
    logic [7:0]      echo_data, echo_data_n, hold_data, hold_data_n;
    logic            echo_full, echo_full_n, hold_full, hold_full_n;
    logic [7:0]      cmd_n, err_n;
    logic            line_byte;

    // Reply ROM; only the first two characters of a line decide the reply,
    // so the line store keeps just that prefix plus a length counter.
    function automatic logic [7:0] reply_char(input logic err, input logic [2:0] idx);
        logic [7:0] c;
        c = 8'h00;
        if (err) begin
            case (idx)
                3'd0: c = 8'h45;
                3'd1: c = 8'h52;
                3'd2: c = 8'h52;
                3'd3: c = 8'h4F;
                3'd4: c = 8'h52;
                3'd5: c = 8'h0D;
                3'd6: c = 8'h0A;
                default: c = 8'h00;
            endcase
        end else begin
            case (idx)
                3'd0: c = 8'h4F;
                3'd1: c = 8'h4B;
                3'd2: c = 8'h0D;
                3'd3: c = 8'h0A;
                default: c = 8'h00;
            endcase
        end
        return c;
    endfunction

    assign reply_len = reply_err ? 3'd7 : 3'd4;
    // at_mode is only followed while the link is fully quiet.
    assign mode_eff  = tx_busy ? mode_q : at_mode;
    assign busy      = (state == RESPOND) || (state == ECHO) || tx_busy;

    // Next-state, TX request and line/echo bookkeeping.
    always_comb begin
        state_n     = state;
        mode_n      = mode_q;
        len_n       = line_len;
        ovf_n       = ovf;
        pre0_n      = pre0;
        pre1_n      = pre1;
        reply_err_n = reply_err;
        rom_idx_n   = rom_idx;
        echo_data_n = echo_data;
        echo_full_n = echo_full;
        hold_data_n = hold_data;
        hold_full_n = hold_full;
        cmd_n       = cmd_count;
        err_n       = err_count;
        tx_load     = 1'b0;
        tx_byte     = 8'h00;
        line_byte   = 1'b0;

        case (state)
            IDLE: begin
                mode_n = mode_eff;
                if (rx_valid) begin
                    if (mode_eff) begin
                        line_byte = 1'b1;
                        state_n   = COLLECT;
                    end else begin
                        echo_data_n = rx_shift;
                        echo_full_n = 1'b1;
                        state_n     = ECHO;
                    end
                end
            end
            COLLECT: line_byte = rx_valid;
            RESPOND: begin
                if (rom_idx < reply_len) begin
                    if (tx_ready) begin
                        tx_load   = 1'b1;
                        tx_byte   = reply_char(reply_err, rom_idx);
                        rom_idx_n = rom_idx + 3'd1;
                    end
                end else if (tx_last) begin
                    state_n = IDLE;
                end
            end
            ECHO: begin
                if (echo_full && tx_ready) begin
                    tx_load     = 1'b1;
                    tx_byte     = echo_data;
                    echo_data_n = hold_data;
                    echo_full_n = hold_full;
                    hold_full_n = 1'b0;
                end
                if (rx_valid) begin
                    if (!echo_full_n) begin
                        echo_data_n = rx_shift;
                        echo_full_n = 1'b1;
                    end else if (!hold_full_n) begin
                        hold_data_n = rx_shift;
                        hold_full_n = 1'b1;
                    end
                end
                if (!echo_full_n && !hold_full_n) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Line handling shared by the first byte (from IDLE) and the rest.
        if (line_byte) begin
            if (rx_shift == 8'h0A) begin
                if ((line_len == '0) && !ovf) begin
                    state_n = IDLE;
                end else begin
                    state_n   = RESPOND;
                    rom_idx_n = 3'd0;
                    if (!ovf && (line_len >= LW'(2)) && (pre0 == 8'h41) && (pre1 == 8'h54)) begin
                        reply_err_n = 1'b0;
                        if (cmd_count != 8'hFF) cmd_n = cmd_count + 8'd1;
                    end else begin
                        reply_err_n = 1'b1;
                        if (err_count != 8'hFF) err_n = err_count + 8'd1;
                    end
                end
                len_n  = '0;
                ovf_n  = 1'b0;
                pre0_n = 8'h00;
                pre1_n = 8'h00;
            end else if (rx_shift != 8'h0D) begin
                if (line_len < LINE_MAX) begin
                    if (line_len == LW'(0)) pre0_n = rx_shift;
                    if (line_len == LW'(1)) pre1_n = rx_shift;
                    len_n = line_len + LW'(1);
                end else begin
                    ovf_n = 1'b1;
                end
            end
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mode_q    <= 1'b1;
            line_len  <= '0;
            ovf       <= 1'b0;
            pre0      <= 8'h00;
            pre1      <= 8'h00;
            reply_err <= 1'b0;
            rom_idx   <= 3'd0;
            echo_data <= 8'h00;
            echo_full <= 1'b0;
            hold_data <= 8'h00;
            hold_full <= 1'b0;
            cmd_count <= 8'h00;
            err_count <= 8'h00;
        end else begin
            state     <= state_n;
            mode_q    <= mode_n;
            line_len  <= len_n;
            ovf       <= ovf_n;
            pre0      <= pre0_n;
            pre1      <= pre1_n;
            reply_err <= reply_err_n;
            rom_idx   <= rom_idx_n;
            echo_data <= echo_data_n;
            echo_full <= echo_full_n;
            hold_data <= hold_data_n;
            hold_full <= hold_full_n;
            cmd_count <= cmd_n;
            err_count <= err_n;
        end
    end

endmodule

// File: tb/tb_hc05_at_responder.sv
// Bench for hc05_at_responder: bit-level UART driver and TX decoder at DIV=16,
// with a queue-based line/reply model.
`timescale 1ns/1ps
module tb_hc05_at_responder;
    localparam int DIV  = 16;
    localparam int MAXL = 32;

    typedef logic [8:0] wq_t[$];
    typedef logic [7:0] bq_t[$];

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic       rxd     = 1'b1;
    logic       at_mode = 1'b1;
    logic       txd, busy, frame_err;
    logic [7:0] cmd_count, err_count;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int m_cmd = 0;
    int m_err = 0;

    wq_t mon_q;     // decoded txd bytes, bit 8 set on a bad stop bit
    wq_t exp_q;     // expected txd bytes
    int  mon_st[$]; // cycle each decoded start bit began
    int  fe_cyc[$]; // cycles where frame_err was seen high

    hc05_at_responder #(.CLK_FREQ(16), .BAUD(1), .MAX_LINE(MAXL)) dut (
        .clk(clk), .reset_n(reset_n), .rxd(rxd), .txd(txd), .at_mode(at_mode),
        .busy(busy), .frame_err(frame_err), .cmd_count(cmd_count), .err_count(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (frame_err === 1'b1) fe_cyc.push_back(cyc);

    // TX decoder: samples mid-bit on the falling clock edge.
    initial begin : tx_monitor
        logic [8:0] w;
        int st;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && txd === 1'b0) begin
                st = cyc;
                w  = '0;
                repeat (DIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    w[i] = txd;
                end
                repeat (DIV) @(negedge clk);
                w[8] = ~txd;
                mon_q.push_back(w);
                mon_st.push_back(st);
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    function automatic logic [287:0] pack(input wq_t q);
        logic [287:0] v;
        v = '0;
        for (int i = 0; i < q.size() && i < 32; i++) v[i*9 +: 9] = q[i];
        return v;
    endfunction

    function automatic bq_t s2q(input string s, input bit crlf);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
        if (crlf) q.push_back(8'h0D);
        q.push_back(8'h0A);
        return q;
    endfunction

    // Reference: store up to MAXL non-CR characters, decide on LF.
    task automatic model_line(input bq_t line);
        bq_t store;
        bit  ovf;
        ovf = 0;
        foreach (line[i]) begin
            if (line[i] == 8'h0A) begin
                if (store.size() == 0 && !ovf) begin
                end else if (!ovf && store.size() >= 2 && store[0] == 8'h41 && store[1] == 8'h54) begin
                    exp_q.push_back(9'h04F); exp_q.push_back(9'h04B);
                    exp_q.push_back(9'h00D); exp_q.push_back(9'h00A);
                    if (m_cmd < 255) m_cmd++;
                end else begin
                    exp_q.push_back(9'h045); exp_q.push_back(9'h052); exp_q.push_back(9'h052);
                    exp_q.push_back(9'h04F); exp_q.push_back(9'h052);
                    exp_q.push_back(9'h00D); exp_q.push_back(9'h00A);
                    if (m_err < 255) m_err++;
                end
                store.delete();
                ovf = 0;
            end else if (line[i] != 8'h0D) begin
                if (store.size() < MAXL) store.push_back(line[i]);
                else ovf = 1;
            end
        end
    endtask

    // Drives one frame starting now; caller is at a falling edge.
    task automatic send_byte(input logic [7:0] b, input logic stop, output int t0);
        t0  = cyc;
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(negedge clk);
        end
        rxd = stop;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send_line(input bq_t q, output int t_first, output int t_last);
        int t;
        t_first = 0;
        t_last  = 0;
        @(negedge clk);
        foreach (q[i]) begin
            send_byte(q[i], 1'b1, t);
            if (i == 0) t_first = t;
            t_last = t;
        end
    endtask

    task automatic wait_idle(output int t_fall);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) begin
            tests++; fails++;
            $display("FAIL busy_timeout: busy=%b still high after %0d cycles, required 0", busy, n);
        end
        t_fall = cyc;
        repeat (20) @(negedge clk);
    endtask

    task automatic clear_q();
        mon_q.delete();
        mon_st.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (txd !== 1'b1) begin fails++; $display("FAIL reset_txd: got %b want 1", txd); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        tests++; if (cmd_count !== 8'd0) begin fails++; $display("FAIL reset_cmd: got %0d want 0", cmd_count); end
        tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL reset_err: got %0d want 0", err_count); end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_at_ok();
        bq_t q; int tf, tl, tfall, st;
        clear_q();
        q = s2q("AT", 1);
        model_line(q);
        send_line(q, tf, tl);
        wait_idle(tfall);
        tests++; if (pack(mon_q) !== pack(exp_q) || mon_q.size() != exp_q.size())
            begin fails++; $display("FAIL ok_reply: got %h (%0d) want %h (%0d)", pack(mon_q), mon_q.size(), pack(exp_q), exp_q.size()); end
        tests++; if (cmd_count !== 8'(m_cmd)) begin fails++; $display("FAIL ok_cmd: got %0d want %0d", cmd_count, m_cmd); end
        tests++; if (err_count !== 8'(m_err)) begin fails++; $display("FAIL ok_err: got %0d want %0d", err_count, m_err); end
        st = (mon_st.size() > 0) ? mon_st[mon_st.size()-1] : -1000;
        tests++; if (tfall != st + 10 * DIV) begin fails++; $display("FAIL ok_busy_fall: got cycle %0d want %0d", tfall, st + 10 * DIV); end
    endtask

    task automatic test_error();
        bq_t q; int tf, tl, tfall;
        clear_q();
        q = s2q("XY", 1);
        model_line(q);
        send_line(q, tf, tl);
        wait_idle(tfall);
        tests++; if (pack(mon_q) !== pack(exp_q) || mon_q.size() != exp_q.size())
            begin fails++; $display("FAIL error_reply: got %h (%0d) want %h (%0d)", pack(mon_q), mon_q.size(), pack(exp_q), exp_q.size()); end
        tests++; if (err_count !== 8'(m_err)) begin fails++; $display("FAIL error_err: got %0d want %0d", err_count, m_err); end
        tests++; if (cmd_count !== 8'(m_cmd)) begin fails++; $display("FAIL error_cmd: got %0d want %0d", cmd_count, m_cmd); end
    endtask

    task automatic test_overflow();
        bq_t q; int tf, tl, tfall;
        string s;
        s = "AT";
        for (int i = 0; i < 38; i++) s = {s, "A"};
        for (int k = 0; k < 2; k++) begin
            clear_q();
            q = (k == 0) ? s2q(s, 0) : s2q("AT", 0);
            model_line(q);
            send_line(q, tf, tl);
            wait_idle(tfall);
            tests++; if (pack(mon_q) !== pack(exp_q) || mon_q.size() != exp_q.size())
                begin fails++; $display("FAIL ovf_reply%0d: got %h (%0d) want %h (%0d)", k, pack(mon_q), mon_q.size(), pack(exp_q), exp_q.size()); end
            tests++; if (cmd_count !== 8'(m_cmd)) begin fails++; $display("FAIL ovf_cmd%0d: got %0d want %0d", k, cmd_count, m_cmd); end
            tests++; if (err_count !== 8'(m_err)) begin fails++; $display("FAIL ovf_err%0d: got %0d want %0d", k, err_count, m_err); end
        end
    endtask

    task automatic test_frame_err();
        int t0, got;
        clear_q();
        fe_cyc.delete();
        @(negedge clk);
        send_byte(8'h41, 1'b0, t0);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        tests++; if (fe_cyc.size() != 1) begin fails++; $display("FAIL fe_pulses: got %0d high cycles want 1", fe_cyc.size()); end
        got = (fe_cyc.size() > 0) ? fe_cyc[0] : -1;
        tests++; if (got != t0 + 154) begin fails++; $display("FAIL fe_cycle: got %0d want %0d", got, t0 + 154); end
        tests++; if (mon_q.size() != 0) begin fails++; $display("FAIL fe_txd: got %0d bytes want 0", mon_q.size()); end
        tests++; if (cmd_count !== 8'(m_cmd)) begin fails++; $display("FAIL fe_cmd: got %0d want %0d", cmd_count, m_cmd); end
        tests++; if (err_count !== 8'(m_err)) begin fails++; $display("FAIL fe_err: got %0d want %0d", err_count, m_err); end
    endtask

    task automatic test_random_lines();
        bq_t q; int tf, tl, tfall, len;
        logic [7:0] c;
        for (int k = 0; k < 5; k++) begin
            clear_q();
            q = {};
            if ($urandom_range(0, 1) == 1) begin q.push_back(8'h41); q.push_back(8'h54); end
            len = $urandom_range(0, 8);
            for (int j = 0; j < len; j++) begin
                case ($urandom_range(0, 4))
                    0: c = 8'h41;
                    1: c = 8'h54;
                    2: c = 8'h0D;
                    3: c = 8'h61;
                    default: c = 8'($urandom_range(32, 126));
                endcase
                q.push_back(c);
            end
            if ($urandom_range(0, 1) == 1) q.push_back(8'h0D);
            q.push_back(8'h0A);
            model_line(q);
            send_line(q, tf, tl);
            wait_idle(tfall);
            tests++; if (pack(mon_q) !== pack(exp_q) || mon_q.size() != exp_q.size())
                begin fails++; $display("FAIL rand_reply%0d: got %h (%0d) want %h (%0d)", k, pack(mon_q), mon_q.size(), pack(exp_q), exp_q.size()); end
            tests++; if (cmd_count !== 8'(m_cmd)) begin fails++; $display("FAIL rand_cmd%0d: got %0d want %0d", k, cmd_count, m_cmd); end
            tests++; if (err_count !== 8'(m_err)) begin fails++; $display("FAIL rand_err%0d: got %0d want %0d", k, err_count, m_err); end
        end
    endtask

    task automatic test_echo();
        bq_t q; int tf, tl, tfall, st;
        at_mode = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            clear_q();
            q = {};
            if (k == 0) begin
                q.push_back(8'h55); q.push_back(8'hA3);
            end else begin
                for (int j = 0; j < 4; j++) q.push_back(8'($urandom_range(0, 255)));
            end
            foreach (q[i]) exp_q.push_back({1'b0, q[i]});
            send_line(q, tf, tl);
            wait_idle(tfall);
            tests++; if (pack(mon_q) !== pack(exp_q) || mon_q.size() != exp_q.size())
                begin fails++; $display("FAIL echo_bytes%0d: got %h (%0d) want %h (%0d)", k, pack(mon_q), mon_q.size(), pack(exp_q), exp_q.size()); end
            st = (mon_st.size() > 0) ? mon_st[0] : -1;
            tests++; if (st != tf + 156) begin fails++; $display("FAIL echo_latency%0d: got cycle %0d want %0d", k, st, tf + 156); end
        end
        tests++; if (cmd_count !== 8'(m_cmd) || err_count !== 8'(m_err))
            begin fails++; $display("FAIL echo_counters: got %0d/%0d want %0d/%0d", cmd_count, err_count, m_cmd, m_err); end
        at_mode = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_reply();
        bq_t q; int tf, tl, tfall;
        clear_q();
        q = s2q("AT", 1);
        send_line(q, tf, tl);
        repeat (200) @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL midreply_busy: got %b want 1", busy); end
        reset_n = 1'b0;
        #1;
        tests++; if (txd !== 1'b1) begin fails++; $display("FAIL midreset_txd: got %b want 1", txd); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b want 0", busy); end
        tests++; if (cmd_count !== 8'd0 || err_count !== 8'd0)
            begin fails++; $display("FAIL midreset_counters: got %0d/%0d want 0/0", cmd_count, err_count); end
        @(negedge clk);
        reset_n = 1'b1;
        m_cmd = 0;
        m_err = 0;
        repeat (300) @(negedge clk);
        clear_q();
        q = s2q("AT", 0);
        model_line(q);
        send_line(q, tf, tl);
        wait_idle(tfall);
        tests++; if (pack(mon_q) !== pack(exp_q) || mon_q.size() != exp_q.size())
            begin fails++; $display("FAIL postreset_reply: got %h (%0d) want %h (%0d)", pack(mon_q), mon_q.size(), pack(exp_q), exp_q.size()); end
        tests++; if (cmd_count !== 8'(m_cmd)) begin fails++; $display("FAIL postreset_cmd: got %0d want %0d", cmd_count, m_cmd); end
        tests++; if (err_count !== 8'(m_err)) begin fails++; $display("FAIL postreset_err: got %0d want %0d", err_count, m_err); end
    endtask

    initial begin : main
        test_reset();
        test_at_ok();
        test_error();
        test_overflow();
        test_frame_err();
        test_random_lines();
        test_echo();
        test_reset_mid_reply();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
